// File: rtl/mdu_ctrl_if.sv
// HI/LO unit handshake bundle between the E stage and mdu_ctrl.
// master: pipeline side drives start/op/a/b/md_use; slave: unit drives busy/stall/hi/lo.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller with fixed-latency busy window.
// Ports: clk, reset (async, active-high), md (mdu_ctrl_if.slave: start/op/a/b/md_use in, busy/stall/hi/lo out).
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave md
);
  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          is_mul, is_div, ld, fin, wr;
  logic          mthi, mtlo, busy, sgn;
  logic [63:0]   ea, eb, prod;
  logic [31:0]   ua, ub, q, r, dq, dr;

  assign is_mul = md.op[2:1] == 2'b00;
  assign is_div = md.op[2:1] == 2'b01;
  assign busy   = state != IDLE;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ld      = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (md.start && (is_mul || is_div)) begin
          ld      = 1'b1;
          state_d = is_mul ? MUL : DIV;
          cnt_d   = is_mul ? CW'(MULT_CYC) : CW'(DIV_CYC);
        end
      end
      MUL, DIV: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (ld) begin
        op_q <= md.op;
        a_q  <= md.a;
        b_q  <= md.b;
      end
    end
  end

  // Signed ops have op[0]=0; sign-extend so one 64x64 multiply covers both.
  assign sgn  = ~op_q[0];
  assign ea   = {{32{sgn & a_q[31]}}, a_q};
  assign eb   = {{32{sgn & b_q[31]}}, b_q};
  assign prod = ea * eb;

  // Magnitude divide keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign ua = (sgn && a_q[31]) ? 32'd0 - a_q : a_q;
  assign ub = (sgn && b_q[31]) ? 32'd0 - b_q : b_q;
  assign q  = (ub == '0) ? '0 : ua / ub;
  assign r  = (ub == '0) ? '0 : ua % ub;
  assign dq = (sgn && (a_q[31] ^ b_q[31])) ? 32'd0 - q : q;
  assign dr = (sgn && a_q[31]) ? 32'd0 - r : r;

  assign wr   = fin && !(op_q[1] && b_q == '0);
  assign mthi = !busy && md.start && md.op == 3'b100;
  assign mtlo = !busy && md.start && md.op == 3'b101;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      unique case (1'b1)
        wr: begin
          if (op_q[1]) {hi_q, lo_q} <= {dr, dq};
          else         {hi_q, lo_q} <= prod;
        end
        mthi:    hi_q <= md.a;
        mtlo:    lo_q <= md.a;
        default: ;
      endcase
    end
  end

  assign md.busy  = busy;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.stall = ~reset & md.md_use &
                    (busy | (md.start & (is_mul | is_div)));
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed table-driven bench for mdu_ctrl.
// Checks busy window, stall, hi/lo results, ignored restarts and reset abort.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_pass = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mdu_ctrl_if mif();

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_vec(input vec_t v);
    mif.start  = 1'b1;
    mif.op     = v.op;
    mif.a      = v.a;
    mif.b      = v.b;
    mif.md_use = 1'b1;
    @(negedge clk);
    chk("start_busy", {31'b0, mif.busy}, 32'd0);
    chk("start_stall", {31'b0, mif.stall}, (v.cyc != 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    mif.start = 1'b0;
    mif.a     = ~v.a;
    mif.b     = 32'h0;
    for (int k = 0; k < v.cyc; k++) begin
      if (k == 1) begin
        mif.start = 1'b1;
        mif.op    = 3'b001;
        mif.a     = 32'd1;
        mif.b     = 32'd1;
      end else begin
        mif.start = 1'b0;
      end
      @(negedge clk);
      chk("busy_hi", {31'b0, mif.busy}, 32'd1);
      chk("busy_stall", {31'b0, mif.stall}, 32'd1);
      chk("busy_hold_hi", mif.hi, cur_hi);
      chk("busy_hold_lo", mif.lo, cur_lo);
      @(posedge clk); #1;
    end
    mif.start = 1'b0;
    @(negedge clk);
    chk("done_busy", {31'b0, mif.busy}, 32'd0);
    chk("done_stall", {31'b0, mif.stall}, 32'd0);
    chk("res_hi", mif.hi, v.hi);
    chk("res_lo", mif.lo, v.lo);
    cur_hi = v.hi;
    cur_lo = v.lo;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
    vecs[8]  = '{3'b101, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
    vecs[9]  = '{3'b000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};
    vecs[10] = '{3'b010, 32'h00000005, 32'h00000000, 32'hC0000000, 32'h80000000, 10};
    vecs[11] = '{3'b110, 32'h55555555, 32'h00000001, 32'hC0000000, 32'h80000000, 0};
    vecs[12] = '{3'b001, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 5};

    reset      = 1'b1;
    mif.start  = 1'b1;
    mif.op     = 3'b000;
    mif.a      = 32'd9;
    mif.b      = 32'd9;
    mif.md_use = 1'b1;
    #2;
    chk("rst_busy", {31'b0, mif.busy}, 32'd0);
    chk("rst_stall", {31'b0, mif.stall}, 32'd0);
    chk("rst_hi", mif.hi, 32'd0);
    chk("rst_lo", mif.lo, 32'd0);
    mif.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // DIV aborted by reset in its fourth busy cycle.
    mif.start = 1'b1;
    mif.op    = 3'b010;
    mif.a     = 32'd100;
    mif.b     = 32'd3;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", {31'b0, mif.busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, mif.busy}, 32'd0);
    chk("abort_stall", {31'b0, mif.stall}, 32'd0);
    chk("abort_hi", mif.hi, 32'd0);
    chk("abort_lo", mif.lo, 32'd0);
    cur_hi = '0;
    cur_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(vecs[12]);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("post_abort_hi", mif.hi, 32'd0);
    chk("post_abort_lo", mif.lo, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYC, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  E-stage HI/LO instruction valid this cycle.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-008 b  input  32  rt operand (divisor / multiplier).
REQ-009 md_use  input  1  E-stage instruction is any HI/LO user (MULT*, DIV*, MTHI, MTLO, MFHI, MFLO).
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 stall  output  1  freeze F/D/E, insert bubble into M.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.

Function
REQ-014 States IDLE, MUL, DIV; counter cnt of at least 4 bits.
REQ-015 IDLE, start=1, op MULT/MULTU: latch a, b, op; cnt<=MULT_CYC; go to MUL.
REQ-016 IDLE, start=1, op DIV/DIVU: latch a, b, op; cnt<=DIV_CYC; go to DIV.
REQ-017 MUL/DIV: cnt decrements each cycle; the edge at which cnt is 1 writes hi/lo and returns to IDLE.
REQ-018 busy is registered: 1 in exactly MULT_CYC (or DIV_CYC) consecutive cycles following the start cycle, 0 otherwise.
REQ-019 Results are visible on hi/lo in the first cycle after busy falls.
REQ-020 MULT: {hi,lo} = signed 64-bit a*b; MULTU: unsigned 64-bit product.
REQ-021 DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of a.
REQ-022 DIVU: lo = unsigned quotient; hi = unsigned remainder.
REQ-023 Divisor b = 0 (DIV or DIVU): full busy duration still elapses; hi and lo are left unchanged.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000; no trap.
REQ-025 MTHI/MTLO with start=1 in IDLE: hi (or lo) <= a at the next edge; busy stays 0; no stall.
REQ-026 start while busy=1 is ignored (state, counter, latched operands, hi and lo are not affected).
REQ-027 Reserved op with start=1: no state change.
REQ-028 stall = md_use & (busy | (start & op is MULT/MULTU/DIV/DIVU)); combinational; drops in the cycle busy falls.
REQ-029 Operands a and b may change after the start cycle without affecting the result.
REQ-030 Only the final edge of an operation writes hi/lo; no intermediate values appear on hi or lo.

Reset
REQ-031 reset=1 forces IDLE, cnt=0, busy=0, hi=0, lo=0 with no clock edge.
REQ-032 stall=0 while reset=1.
REQ-033 reset asserted mid-operation aborts it: no result is written, and the block accepts start in the first cycle after reset is released.

Verification
REQ-034 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-036 DIV a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/0 -> hi and lo unchanged after 10 busy cycles.
REQ-037 MULT start, then MFLO (md_use=1) held 5 cycles -> stall=1 in the start cycle and all 5 busy cycles; stall=0 in the next cycle with lo valid. A second start during busy is ignored.
REQ-038 MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy=0, stall=0.
REQ-039 DIV start, reset pulse in busy cycle 4 -> busy=0, hi=lo=0 immediately; a new MULTU 2*3 issued after release -> lo=6.
